// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
//
// Read-domain adapter that sits directly behind an asynchronous FIFO. It turns
// the FIFO pop interface (rd_en / rd_empty, data registered one cycle after the
// pop) into a first-word-fall-through valid/ready stream. A head register and a
// skid register form a 2-entry buffer so the stream runs at full rate even
// under back-pressure. A synchronous flush discards everything buffered or in
// flight, and a wrapping counter tallies accepted output transfers.
//
// Ports:
//   rd_clk         read-domain clock
//   rd_rst_n       asynchronous active-low reset
//   fifo_rd_en     pop request to the FIFO (combinational)
//   fifo_rd_empty  FIFO empty flag
//   fifo_rd_data   FIFO read data, valid the cycle after a pop
//   m_valid        output word available
//   m_ready        downstream accepts the word
//   m_data         output word (head register)
//   flush          discard all buffered and in-flight words
//   level          words held in the buffer (0..2)
//   word_count     accepted output transfers, wrapping
module fifo_rd_stream_adapter #(
   parameter int unsigned BITS     = 32,
   parameter int unsigned CNT_BITS = 16
) (
   input  logic                rd_clk,
   input  logic                rd_rst_n,
   output logic                fifo_rd_en,
   input  logic                fifo_rd_empty,
   input  logic [BITS-1:0]     fifo_rd_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [BITS-1:0]     m_data,
   input  logic                flush,
   output logic [1:0]          level,
   output logic [CNT_BITS-1:0] word_count
);

   localparam logic [1:0] LvlEmpty = 2'd0;
   localparam logic [1:0] LvlOne   = 2'd1;
   localparam logic [1:0] LvlTwo   = 2'd2;

   logic [1:0]          level_q, level_d;
   logic                inflight_q, inflight_d;
   logic [BITS-1:0]     head_q, head_d;
   logic [BITS-1:0]     skid_q, skid_d;
   logic [CNT_BITS-1:0] count_q, count_d;

   logic       pop;
   logic       arr;
   logic [2:0] occ_after_pop;

   assign m_valid    = (level_q != LvlEmpty);
   assign m_data     = head_q;
   assign level      = level_q;
   assign word_count = count_q;

   assign pop = m_valid && m_ready;
   // A word popped from the FIFO on the previous edge arrives on this edge.
   assign arr = inflight_q;

   // Occupancy counting the word in flight, minus the word leaving this cycle.
   // pop implies level_q >= 1, so this never underflows.
   assign occ_after_pop = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop};

   // rd_rst_n gates the request so the FIFO is never popped while held in reset.
   assign fifo_rd_en = rd_rst_n && !fifo_rd_empty && !flush && (occ_after_pop < 3'd2);

   always_comb begin
      level_d    = level_q;
      head_d     = head_q;
      skid_d     = skid_q;
      inflight_d = fifo_rd_en;
      count_d    = pop ? count_q + {{(CNT_BITS-1){1'b0}}, 1'b1} : count_q;

      if (flush) begin
         // Buffered words and the word arriving now are all dropped.
         level_d    = LvlEmpty;
         inflight_d = 1'b0;
      end else begin
         case (level_q)
            LvlEmpty: begin
               if (arr) begin
                  head_d  = fifo_rd_data;
                  level_d = LvlOne;
               end
            end
            LvlOne: begin
               if (arr && !pop) begin
                  skid_d  = fifo_rd_data;
                  level_d = LvlTwo;
               end else if (pop && !arr) begin
                  level_d = LvlEmpty;
               end else if (pop && arr) begin
                  head_d = fifo_rd_data;
               end
            end
            LvlTwo: begin
               if (pop) begin
                  head_d = skid_q;
                  if (arr) begin
                     skid_d = fifo_rd_data;
                  end else begin
                     level_d = LvlOne;
                  end
               end
            end
            default: begin
               level_d = LvlEmpty;
            end
         endcase
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         level_q    <= LvlEmpty;
         inflight_q <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
         count_q    <= '0;
      end else begin
         level_q    <= level_d;
         inflight_q <= inflight_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         count_q    <= count_d;
      end
   end

   // The issue rule must keep a third word from arriving into a full buffer.
   a_no_overflow : assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
      !(level_q == LvlTwo && inflight_q && !pop));

endmodule
